// File: rtl/gcn_sched_pkg.sv
// Shared types and default constants for the GCN layer scheduler.
package gcn_sched_pkg;

    localparam int DEFAULT_NUM_LAYERS     = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_TRANS_START,
        S_TRANS_WAIT,
        S_AGG_START,
        S_AGG_WAIT,
        S_NEXT_LAYER,
        S_DONE,
        S_ERROR
    } schedState_e;

endpackage

// File: rtl/sched_timeout_counter.sv
// Per-phase wait timer: cleared before each WAIT phase, counts stalled
// cycles and flags the last allowed one so the FSM can abort the run.
module sched_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam int CNT_BW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_BW-1:0] count_q;
    logic [CNT_BW-1:0] count_d;

    assign terminal_o = (count_q == CNT_BW'(TIMEOUT_CYCLES - 1));

    // Next count: clear wins, otherwise step while enabled and saturate at terminal
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !terminal_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/gcn_layer_scheduler.sv
// Sequences the transformation and aggregation engines across all GCN layers,
// ping-ponging the feature buffers and aborting on a stalled engine phase.
module gcn_layer_scheduler
    import gcn_sched_pkg::*;
#(
    parameter int NUM_LAYERS     = DEFAULT_NUM_LAYERS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int LAYER_BW       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                trans_done,
    input  logic                agg_done,
    output logic                eng_clear,
    output logic                trans_start,
    output logic                agg_start,
    output logic [LAYER_BW-1:0] layer_idx,
    output logic                buf_sel,
    output logic                busy,
    output logic                done,
    output logic                error
);

    schedState_e         state_q, state_d;
    logic [LAYER_BW-1:0] layerIdx_q, layerIdx_d;
    logic                bufSel_q, bufSel_d;

    logic timerClear;
    logic timerEnable;
    logic timerTerminal;
    logic lastLayer;

    // Timer restarts in the START state so each WAIT phase begins at zero
    assign timerClear  = (state_q == S_TRANS_START) || (state_q == S_AGG_START);
    assign timerEnable = ((state_q == S_TRANS_WAIT) && !trans_done) ||
                         ((state_q == S_AGG_WAIT)   && !agg_done);
    assign lastLayer   = (layerIdx_q == LAYER_BW'(NUM_LAYERS - 1));

    sched_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (timerClear),
        .enable_i   (timerEnable),
        .terminal_o (timerTerminal)
    );

    // Next-state logic; engine done levels are only looked at in their own WAIT state
    always_comb begin
        state_d    = state_q;
        layerIdx_d = layerIdx_q;
        bufSel_d   = bufSel_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_CLEAR;
                    layerIdx_d = '0;
                    bufSel_d   = 1'b0;
                end
            end
            S_CLEAR:       state_d = S_TRANS_START;
            S_TRANS_START: state_d = S_TRANS_WAIT;
            S_TRANS_WAIT: begin
                if (trans_done) begin
                    state_d = S_AGG_START;
                end else if (timerTerminal) begin
                    state_d = S_ERROR;
                end
            end
            S_AGG_START:   state_d = S_AGG_WAIT;
            S_AGG_WAIT: begin
                if (agg_done) begin
                    state_d = S_NEXT_LAYER;
                end else if (timerTerminal) begin
                    state_d = S_ERROR;
                end
            end
            S_NEXT_LAYER: begin
                if (lastLayer) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_CLEAR;
                    layerIdx_d = layerIdx_q + 1'b1;
                    bufSel_d   = ~bufSel_q;
                end
            end
            S_ERROR:       state_d = S_ERROR;
            default:       state_d = S_IDLE;
        endcase
    end

    // State, layer counter and buffer select registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            layerIdx_q <= '0;
            bufSel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            layerIdx_q <= layerIdx_d;
            bufSel_q   <= bufSel_d;
        end
    end

    assign eng_clear   = (state_q == S_CLEAR);
    assign trans_start = (state_q == S_TRANS_START);
    assign agg_start   = (state_q == S_AGG_START);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign busy        = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    assign layer_idx   = layerIdx_q;
    assign buf_sel     = bufSel_q;

endmodule

// File: tb/tb_gcn_layer_scheduler.sv
// Scoreboard bench for gcn_layer_scheduler with a behavioural engine model.
module tb_gcn_layer_scheduler;

    typedef enum int {EV_CLEAR, EV_TSTART, EV_ASTART, EV_DONE, EV_ERROR} evKind_e;

    typedef struct {
        evKind_e kind;
        int      layer;
        int      bufSel;
    } expEvent_t;

    logic clk;
    logic reset;
    logic start;
    logic trans_done;
    logic agg_done;
    logic eng_clear;
    logic trans_start;
    logic agg_start;
    logic [0:0] layer_idx;
    logic buf_sel;
    logic busy;
    logic done;
    logic error;

    int totalChecks = 0;
    int badChecks   = 0;
    expEvent_t expQ[$];

    int transDelay = 3;
    int aggDelay   = 5;
    int transCnt   = 0;
    int aggCnt     = 0;

    gcn_layer_scheduler #(
        .NUM_LAYERS     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .trans_done  (trans_done),
        .agg_done    (agg_done),
        .eng_clear   (eng_clear),
        .trans_start (trans_start),
        .agg_start   (agg_start),
        .layer_idx   (layer_idx),
        .buf_sel     (buf_sel),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushEvent(input evKind_e kind, input int layer, input int bufSel);
        expEvent_t e;
        e.kind   = kind;
        e.layer  = layer;
        e.bufSel = bufSel;
        expQ.push_back(e);
    endtask

    // One full two-layer run: layer n uses source buffer n
    task automatic pushRun();
        for (int l = 0; l < 2; l++) begin
            pushEvent(EV_CLEAR,  l, l);
            pushEvent(EV_TSTART, l, l);
            pushEvent(EV_ASTART, l, l);
        end
        pushEvent(EV_DONE, 1, 1);
    endtask

    task automatic applyStimulus(input int tDelay, input int aDelay);
        transDelay = tDelay;
        aggDelay   = aDelay;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitForDone(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("run_done", int'(done), 1);
    endtask

    task automatic handleEvent(input evKind_e kind);
        expEvent_t e;
        if (expQ.size() == 0) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = expQ.pop_front();
            checkOutput("event_kind", int'(kind), int'(e.kind));
            checkOutput("event_layer", int'(layer_idx), e.layer);
            checkOutput("event_bufsel", int'(buf_sel), e.bufSel);
        end
    endtask

    // Engine model: done rises `delay` cycles after the start pulse, held until cleared
    initial begin
        trans_done = 1'b0;
        agg_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 || eng_clear === 1'b1) begin
                trans_done = 1'b0;
                agg_done   = 1'b0;
                transCnt   = 0;
                aggCnt     = 0;
            end
            if (transCnt > 0) begin
                transCnt--;
                if (transCnt == 0) trans_done = 1'b1;
            end
            if (aggCnt > 0) begin
                aggCnt--;
                if (aggCnt == 0) agg_done = 1'b1;
            end
            if (trans_start === 1'b1 && transDelay > 0) transCnt = transDelay;
            if (agg_start === 1'b1 && aggDelay > 0) aggCnt = aggDelay;
        end
    end

    // Monitor: every pulse and every rising done/error is matched against the queue
    initial begin
        logic prevDone;
        logic prevError;
        prevDone  = 1'b0;
        prevError = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_clear === 1'b1)   handleEvent(EV_CLEAR);
            if (trans_start === 1'b1) handleEvent(EV_TSTART);
            if (agg_start === 1'b1)   handleEvent(EV_ASTART);
            if (done === 1'b1 && prevDone !== 1'b1)   handleEvent(EV_DONE);
            if (error === 1'b1 && prevError !== 1'b1) handleEvent(EV_ERROR);
            prevDone  = done;
            prevError = error;
        end
    end

    // Directed scenarios
    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_flags", int'({eng_clear, trans_start, agg_start, busy, done, error}), 0);
        checkOutput("reset_layer", int'(layer_idx), 0);
        checkOutput("reset_bufsel", int'(buf_sel), 0);
        reset = 1'b0;

        // Idle with no start
        repeat (10) @(negedge clk);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_done", int'(done), 0);

        // Normal run: trans 3 cycles, agg 5 cycles
        pushRun();
        applyStimulus(3, 5);
        waitForDone(200);
        repeat (5) @(negedge clk);
        checkOutput("done_held", int'(done), 1);
        checkOutput("final_layer", int'(layer_idx), 1);
        checkOutput("final_bufsel", int'(buf_sel), 1);
        checkOutput("queue_drained_run1", expQ.size(), 0);

        // Restart from DONE
        pushRun();
        applyStimulus(3, 5);
        waitForDone(200);
        checkOutput("queue_drained_run2", expQ.size(), 0);

        // agg_done arrives exactly in the last allowed wait cycle
        pushRun();
        applyStimulus(2, 16);
        waitForDone(300);
        checkOutput("boundary_no_error", int'(error), 0);
        checkOutput("queue_drained_boundary", expQ.size(), 0);

        // Reset in the middle of layer-1 AGG_WAIT
        for (int l = 0; l < 2; l++) begin
            pushEvent(EV_CLEAR,  l, l);
            pushEvent(EV_TSTART, l, l);
            pushEvent(EV_ASTART, l, l);
        end
        applyStimulus(3, 10);
        n = 0;
        while (!(agg_start && layer_idx == 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_layer1_agg", int'(agg_start), 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midrun_reset_busy", int'(busy), 0);
        checkOutput("midrun_reset_layer", int'(layer_idx), 0);
        checkOutput("midrun_reset_bufsel", int'(buf_sel), 0);
        checkOutput("midrun_reset_flags", int'({eng_clear, trans_start, agg_start, done, error}), 0);
        checkOutput("queue_drained_reset", expQ.size(), 0);

        // Transformation engine never finishes: timeout after 16 wait cycles
        pushEvent(EV_CLEAR,  0, 0);
        pushEvent(EV_TSTART, 0, 0);
        pushEvent(EV_ERROR,  0, 0);
        applyStimulus(-1, 5);
        n = 0;
        while (!trans_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("timeout_trans_start_seen", int'(trans_start), 1);
        repeat (16) @(negedge clk);
        checkOutput("timeout_not_yet", int'(error), 0);
        checkOutput("timeout_busy_last_wait", int'(busy), 1);
        @(negedge clk);
        checkOutput("timeout_error", int'(error), 1);
        start = 1'b1;
        repeat (5) @(negedge clk);
        start = 1'b0;
        checkOutput("error_sticky", int'(error), 1);
        checkOutput("error_ignores_start", int'({busy, done, eng_clear}), 0);
        checkOutput("queue_drained_timeout", expQ.size(), 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("error_cleared_by_reset", int'(error), 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/gcn_layer_scheduler.md
GCN_LAYER_SCHEDULER -- requirements
Module: gcn_layer_scheduler

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2: number of GCN layers per run (at least 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum number of wait cycles per engine phase (at least 2).
REQ-003 SHALL have parameter LAYER_BW, default $clog2(NUM_LAYERS) (minimum 1): width of layer_idx.
REQ-004 SHALL use a single clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk  input  1  system clock; all flops update on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port start  input  1  run request, sampled only in IDLE or DONE.
REQ-008 SHALL have port trans_done  input  1  feature x weight transformation engine done (level).
REQ-009 SHALL have port agg_done  input  1  COO-edge aggregation engine done (level, held by engine).
REQ-010 SHALL have port eng_clear  output  1  one-cycle synchronous clear to both engines.
REQ-011 SHALL have port trans_start  output  1  one-cycle start pulse to the transformation engine.
REQ-012 SHALL have port agg_start  output  1  one-cycle start pulse to the aggregation engine.
REQ-013 SHALL have port layer_idx  output  LAYER_BW  current layer number.
REQ-014 SHALL have port buf_sel  output  1  ping-pong feature-buffer select (source = buf_sel, destination = ~buf_sel).
REQ-015 SHALL have port busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-016 SHALL have port done  output  1  run complete; held high.
REQ-017 SHALL have port error  output  1  phase timeout; sticky.

Function
REQ-018 SHALL implement a registered-state FSM with states IDLE, CLEAR, TRANS_START, TRANS_WAIT, AGG_START, AGG_WAIT, NEXT_LAYER, DONE and ERROR.
REQ-019 SHALL decode all outputs from the current state only (Moore): eng_clear in CLEAR; trans_start in TRANS_START; agg_start in AGG_START; done in DONE; error in ERROR.
REQ-020 SHALL, in IDLE with start=1, go to CLEAR with layer_idx=0 and buf_sel=0; with start=0, remain in IDLE.
REQ-021 SHALL transition unconditionally CLEAR -> TRANS_START -> TRANS_WAIT, and AGG_START -> AGG_WAIT.
REQ-022 SHALL, in TRANS_WAIT, go to AGG_START when trans_done=1; in AGG_WAIT, go to NEXT_LAYER when agg_done=1.
REQ-023 SHALL clear the phase timer to 0 on entry to each WAIT state, and increment it every WAIT cycle in which done is low.
REQ-024 SHALL go to ERROR if the phase timer equals TIMEOUT_CYCLES-1 while done is low.
REQ-025 SHALL give done priority over timeout when both occur in the same cycle, so no error is raised.
REQ-026 SHALL, in NEXT_LAYER, go to DONE if layer_idx==NUM_LAYERS-1; otherwise increment layer_idx, toggle buf_sel and go to CLEAR.
REQ-027 SHALL hold layer_idx and buf_sel at their final values in DONE.
REQ-028 SHALL, in DONE with start=1, restart through CLEAR with layer_idx=0 and buf_sel=0.
REQ-029 SHALL hold ERROR until reset, ignoring start.
REQ-030 SHALL ignore start in all states other than IDLE and DONE.
REQ-031 SHALL ignore trans_done and agg_done outside their own WAIT state, since stale levels from a previous layer are cleared by CLEAR.
REQ-032 SHALL take a minimum of 6 cycles per layer (CLEAR through NEXT_LAYER) when done inputs are already high in their WAIT states.

Reset
REQ-033 SHALL, on reset=1 at a clock edge and from any state (including mid-run), set state=IDLE, timer=0, layer_idx=0 and buf_sel=0.
REQ-034 SHALL drive all pulse and flag outputs (eng_clear, trans_start, agg_start, busy, done, error) to 0 in the cycle after reset.

Structure
REQ-035 SHALL place the state enum type and the default NUM_LAYERS and TIMEOUT_CYCLES constants in the shared package gcn_sched_pkg.
REQ-036 SHALL implement the phase timer as sub-module sched_timeout_counter, with clear, enable and terminal-count ports parameterised by TIMEOUT_CYCLES.

Verification (NUM_LAYERS=2, TIMEOUT_CYCLES=16)
REQ-037 SHALL cover: reset held for 2 cycles -> all outputs 0, layer_idx=0, buf_sel=0; start=0 for 10 cycles -> FSM stays in IDLE.
REQ-038 SHALL cover: start pulse, trans_done rising 3 cycles after trans_start, agg_done rising 5 cycles after agg_start -> eng_clear, trans_start and agg_start each pulse exactly twice; layer_idx 0 then 1; buf_sel 0 then 1; done high and held.
REQ-039 SHALL cover: trans_done held at 0 -> error rises on the 16th TRANS_WAIT cycle and stays high; start=1 is then ignored.
REQ-040 SHALL cover: agg_done rising in the cycle the timer equals 15 -> NEXT_LAYER is entered and error stays 0.
REQ-041 SHALL cover: reset asserted during layer-1 AGG_WAIT -> the next cycle shows IDLE, layer_idx=0, buf_sel=0, busy=0.
REQ-042 SHALL cover: start pulse in DONE -> eng_clear pulses once, layer_idx=0, buf_sel=0, and a full second run completes.
